// File: rtl/ps2_kbd_rx_if.sv
// Key-event stream from the PS/2 receiver to the keyboard matrix logic.
// The receiver drives the master side; the consumer drives ev_ready.
interface ps2_kbd_rx_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_rel;

  modport master (output ev_valid, output ev_code, output ev_ext, output ev_rel, input ev_ready);
  modport slave  (input ev_valid, input ev_code, input ev_ext, input ev_rel, output ev_ready);
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: de-glitches the line pair, deserialises device-to-host
// frames, folds E0/F0 prefixes into flags and queues key events in a FWFT FIFO.
module ps2_kbd_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  ps2clk,
  input  logic  ps2dat,
  ps2_kbd_rx_if.master ev,
  output logic  err_parity,
  output logic  err_frame,
  output logic  err_timeout,
  output logic  overflow
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

  // Bit 0 carries the PS/2 clock, bit 1 the PS/2 data; idle level is high.
  logic [1:0]    sync1_q, sync2_q, filt_q, filt_d;
  logic [FW-1:0] fcnt_q [2];
  logic [FW-1:0] fcnt_d [2];
  logic          prevClk_q;
  logic          fall;

  state_t        state_q, state_d;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] toCnt_q, toCnt_d;
  logic          pendExt_q, pendExt_d, pendRel_q, pendRel_d;
  logic          errPar_q, errPar_d, errFrm_q, errFrm_d, errTo_q, errTo_d, ovf_q, ovf_d;
  logic          push;
  logic [9:0]    pushData;

  logic [9:0]    fifoMem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q, count_d;
  logic          empty, full, pop, wrEn;
  logic [9:0]    head;

  // A level only moves after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      fcnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FW'(FILTER_LEN - 1)) filt_d[i] = sync2_q[i];
        else                                  fcnt_d[i] = fcnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      filt_q    <= 2'b11;
      prevClk_q <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      sync1_q   <= {ps2dat, ps2clk};
      sync2_q   <= sync1_q;
      filt_q    <= filt_d;
      prevClk_q <= filt_q[0];
      for (int i = 0; i < 2; i++) fcnt_q[i] <= fcnt_d[i];
    end
  end

  assign fall = prevClk_q & ~filt_q[0];

  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    toCnt_d   = '0;
    pendExt_d = pendExt_q;
    pendRel_d = pendRel_q;
    errPar_d  = 1'b0;
    errFrm_d  = 1'b0;
    errTo_d   = 1'b0;
    push      = 1'b0;
    pushData  = {pendExt_q, pendRel_q, shift_q};
    case (state_q)
      IDLE: if (fall && !filt_q[1]) begin
        state_d  = DATA;
        bitCnt_d = 3'd0;
      end
      DATA: if (fall) begin
        shift_d  = {filt_q[1], shift_q[7:1]};
        bitCnt_d = bitCnt_q + 3'd1;
        if (bitCnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (fall) begin
        parity_d = filt_q[1];
        state_d  = STOP;
      end
      STOP: if (fall) begin
        state_d = IDLE;
        if (!(^{shift_q, parity_q})) begin
          errPar_d  = 1'b1;
          pendExt_d = 1'b0;
          pendRel_d = 1'b0;
        end else if (!filt_q[1]) begin
          errFrm_d  = 1'b1;
          pendExt_d = 1'b0;
          pendRel_d = 1'b0;
        end else if (shift_q == 8'hE0) begin
          pendExt_d = 1'b1;
        end else if (shift_q == 8'hF0) begin
          pendRel_d = 1'b1;
        end else begin
          push      = 1'b1;
          pendExt_d = 1'b0;
          pendRel_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Transitions above happen only on fall, so the timeout never collides with them.
    if (state_q != IDLE) begin
      if (fall) begin
        toCnt_d = '0;
      end else if (toCnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d   = IDLE;
        errTo_d   = 1'b1;
        pendExt_d = 1'b0;
        pendRel_d = 1'b0;
      end else begin
        toCnt_d = toCnt_q + 1'b1;
      end
    end
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign pop   = !empty && ev.ev_ready;
  assign wrEn  = push && (!full || pop);
  assign ovf_d = push && full && !pop;

  always_comb begin
    count_d = count_q;
    if (wrEn && !pop)      count_d = count_q + 1'b1;
    else if (!wrEn && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      toCnt_q   <= '0;
      pendExt_q <= 1'b0;
      pendRel_q <= 1'b0;
      errPar_q  <= 1'b0;
      errFrm_q  <= 1'b0;
      errTo_q   <= 1'b0;
      ovf_q     <= 1'b0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      toCnt_q   <= toCnt_d;
      pendExt_q <= pendExt_d;
      pendRel_q <= pendRel_d;
      errPar_q  <= errPar_d;
      errFrm_q  <= errFrm_d;
      errTo_q   <= errTo_d;
      ovf_q     <= ovf_d;
      wrPtr_q   <= wrPtr_q + PW'(wrEn);
      rdPtr_q   <= rdPtr_q + PW'(pop);
      count_q   <= count_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wrEn) fifoMem[wrPtr_q] <= pushData;
  end

  assign head        = empty ? 10'd0 : fifoMem[rdPtr_q];
  assign ev.ev_valid = !empty;
  assign ev.ev_code  = head[7:0];
  assign ev.ev_rel   = head[8];
  assign ev.ev_ext   = head[9];

  assign err_parity  = errPar_q;
  assign err_frame   = errFrm_q;
  assign err_timeout = errTo_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed self-checking bench for ps2_kbd_rx; the PS/2 clock is compressed
// to 80 system cycles per bit and the timeout shortened to keep the run short.
module tb_ps2_kbd_rx;

  localparam int HALF = 40;
  localparam int GAP  = 120;
  localparam int TMO  = 2000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ps2clk = 1'b1;
  logic ps2dat = 1'b1;
  logic errPar, errFrm, errTo, ovf;

  int checks = 0;
  int errors = 0;
  int parCnt = 0, frmCnt = 0, toCnt = 0, ovfCnt = 0, fallCnt = 0;
  int fallSnap;
  logic [7:0] ovfCodes [4];

  ps2_kbd_rx_if evIf();

  ps2_kbd_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ps2clk      (ps2clk),
    .ps2dat      (ps2dat),
    .ev          (evIf),
    .err_parity  (errPar),
    .err_frame   (errFrm),
    .err_timeout (errTo),
    .overflow    (ovf)
  );

  always #5 clk = ~clk;

  // Pulse monitor: each one-cycle strobe is counted exactly once.
  always @(negedge clk) begin
    if (errPar) parCnt++;
    if (errFrm) frmCnt++;
    if (errTo) toCnt++;
    if (ovf) ovfCnt++;
    if (dut.fall) fallCnt++;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Sends the first nBits bits of a frame: start, 8 data LSB-first, parity, stop.
  task automatic applyStimulus(input logic [7:0] data, input logic parFlip, input logic stopBit, input int nBits);
    logic [10:0] bits;
    bits = {stopBit, (~^data) ^ parFlip, data, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      ps2dat = bits[i];
      waitCycles(HALF);
      ps2clk = 1'b0;
      waitCycles(HALF);
      ps2clk = 1'b1;
    end
    ps2dat = 1'b1;
    waitCycles(GAP);
  endtask

  task automatic popOne(input string tag, input logic [7:0] code, input logic ext, input logic rel);
    @(negedge clk);
    checkOutput({tag, "_valid"}, 32'(evIf.ev_valid), 32'd1);
    checkOutput({tag, "_code"}, 32'(evIf.ev_code), 32'(code));
    checkOutput({tag, "_ext"}, 32'(evIf.ev_ext), 32'(ext));
    checkOutput({tag, "_rel"}, 32'(evIf.ev_rel), 32'(rel));
    evIf.ev_ready = 1'b1;
    @(negedge clk);
    evIf.ev_ready = 1'b0;
  endtask

  initial begin
    evIf.ev_ready = 1'b0;
    ovfCodes[0] = 8'h16;
    ovfCodes[1] = 8'h1E;
    ovfCodes[2] = 8'h26;
    ovfCodes[3] = 8'h25;

    waitCycles(5);
    checkOutput("rst_valid", 32'(evIf.ev_valid), 32'd0);
    checkOutput("rst_code", 32'(evIf.ev_code), 32'd0);
    checkOutput("rst_flags", 32'({evIf.ev_ext, evIf.ev_rel, errPar, errFrm, errTo, ovf}), 32'd0);
    reset_n = 1'b1;
    waitCycles(20);

    // Make code
    applyStimulus(8'h1C, 1'b0, 1'b1, 11);
    popOne("make", 8'h1C, 1'b0, 1'b0);
    checkOutput("make_noerr", 32'(parCnt + frmCnt + toCnt + ovfCnt), 32'd0);
    checkOutput("make_empty", 32'(evIf.ev_valid), 32'd0);

    // Prefix folding
    applyStimulus(8'hE0, 1'b0, 1'b1, 11);
    applyStimulus(8'hF0, 1'b0, 1'b1, 11);
    checkOutput("prefix_nopush", 32'(evIf.ev_valid), 32'd0);
    applyStimulus(8'h75, 1'b0, 1'b1, 11);
    popOne("prefix", 8'h75, 1'b1, 1'b1);
    checkOutput("prefix_single", 32'(evIf.ev_valid), 32'd0);
    applyStimulus(8'h29, 1'b0, 1'b1, 11);
    popOne("prefix_clr", 8'h29, 1'b0, 1'b0);

    // Parity error, which also drops a pending E0
    applyStimulus(8'hE0, 1'b0, 1'b1, 11);
    applyStimulus(8'h1C, 1'b1, 1'b1, 11);
    checkOutput("par_pulse", 32'(parCnt), 32'd1);
    checkOutput("par_novalid", 32'(evIf.ev_valid), 32'd0);
    applyStimulus(8'h1C, 1'b0, 1'b1, 11);
    popOne("par_after", 8'h1C, 1'b0, 1'b0);

    // Bad stop bit with good parity
    applyStimulus(8'h1C, 1'b0, 1'b0, 11);
    checkOutput("frm_pulse", 32'(frmCnt), 32'd1);
    checkOutput("frm_nopar", 32'(parCnt), 32'd1);
    checkOutput("frm_novalid", 32'(evIf.ev_valid), 32'd0);

    // Timeout after start plus 4 data bits
    applyStimulus(8'h29, 1'b0, 1'b1, 5);
    waitCycles(TMO + 10);
    checkOutput("to_pulse", 32'(toCnt), 32'd1);
    checkOutput("to_idle", 32'(dut.state_q), 32'd0);
    checkOutput("to_novalid", 32'(evIf.ev_valid), 32'd0);
    applyStimulus(8'h29, 1'b0, 1'b1, 11);
    popOne("to_after", 8'h29, 1'b0, 1'b0);

    // Overflow and ordering
    applyStimulus(8'h16, 1'b0, 1'b1, 11);
    applyStimulus(8'h1E, 1'b0, 1'b1, 11);
    applyStimulus(8'h26, 1'b0, 1'b1, 11);
    applyStimulus(8'h25, 1'b0, 1'b1, 11);
    checkOutput("ovf_none4", 32'(ovfCnt), 32'd0);
    applyStimulus(8'h2E, 1'b0, 1'b1, 11);
    checkOutput("ovf_pulse", 32'(ovfCnt), 32'd1);
    evIf.ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("ovf_valid%0d", i), 32'(evIf.ev_valid), 32'd1);
      checkOutput($sformatf("ovf_code%0d", i), 32'(evIf.ev_code), 32'(ovfCodes[i]));
      @(negedge clk);
    end
    checkOutput("ovf_drained", 32'(evIf.ev_valid), 32'd0);
    evIf.ev_ready = 1'b0;

    // Short glitch on the clock line while idle
    fallSnap = fallCnt;
    ps2clk = 1'b0;
    waitCycles(3);
    ps2clk = 1'b1;
    waitCycles(30);
    checkOutput("glitch_nofall", 32'(fallCnt), 32'(fallSnap));
    checkOutput("glitch_idle", 32'(dut.state_q), 32'd0);
    checkOutput("glitch_novalid", 32'(evIf.ev_valid), 32'd0);

    // Reset mid-frame with two events buffered
    applyStimulus(8'h16, 1'b0, 1'b1, 11);
    applyStimulus(8'h1E, 1'b0, 1'b1, 11);
    checkOutput("rst2_buffered", 32'(evIf.ev_valid), 32'd1);
    applyStimulus(8'h45, 1'b0, 1'b1, 4);
    reset_n = 1'b0;
    #1;
    checkOutput("rst2_valid", 32'(evIf.ev_valid), 32'd0);
    checkOutput("rst2_code", 32'(evIf.ev_code), 32'd0);
    checkOutput("rst2_flags", 32'({evIf.ev_ext, evIf.ev_rel, errPar, errFrm, errTo, ovf}), 32'd0);
    waitCycles(5);
    reset_n = 1'b1;
    waitCycles(20);
    checkOutput("rst2_idle", 32'(dut.state_q), 32'd0);
    checkOutput("rst2_empty", 32'(evIf.ev_valid), 32'd0);
    applyStimulus(8'h1C, 1'b0, 1'b1, 11);
    popOne("rst2_after", 8'h1C, 1'b0, 1'b0);
    checkOutput("final_errs", 32'({parCnt[3:0], frmCnt[3:0], toCnt[3:0], ovfCnt[3:0]}), 32'h1111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
